// File: rtl/core_pipe_ctrl_pkg.sv
// Shared types for the core pipeline controller: PC source select and
// sequencer state encoding.
package structures;

   typedef enum logic [1:0] {
      PC_SEQ     = 2'd0,
      PC_BRANCH  = 2'd1,
      PC_EXC_VEC = 2'd2,
      PC_EPC     = 2'd3
   } pc_src_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_WAIT  = 2'd1,
      ST_EXC_HOLD = 2'd2
   } pipe_ctrl_state_t;

   localparam int REG_W = 5;

endpackage

// File: rtl/core_hazard_detect.sv
// Combinational load-use detector: an EX-stage load whose destination is read
// by the instruction currently in ID.
module core_hazard_detect
   import structures::*;
(
   input  logic             ex_load,
   input  logic             ex_write_enable,
   input  logic [REG_W-1:0] ex_W_regnum,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_B_is_reg,
   output logic             load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = id_uses_rs  & (id_rs == ex_W_regnum);
   assign rt_hit   = id_B_is_reg & (id_rt == ex_W_regnum);
   // $0 is hardwired to zero, so a load targeting it never creates a hazard
   assign load_use = ex_load & ex_write_enable & (ex_W_regnum != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/core_pipe_ctrl.sv
// Central stall/flush/redirect sequencer: resolves exception, ERET, branch,
// mul/div interlock and load-use hazards in fixed priority order.
module core_pipe_ctrl
   import structures::*;
#(
   parameter int MD_TIMEOUT      = 40,
   parameter int MD_CNT_W        = 6,
   parameter int EXC_HOLD_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_B_is_reg,
   input  logic             id_md_use,
   input  logic             ex_load,
   input  logic             ex_write_enable,
   input  logic [REG_W-1:0] ex_W_regnum,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             md_done,
   input  logic             exc_req,
   input  logic             eret_req,
   output logic             if_stall,
   output logic             id_stall,
   output logic             id_flush,
   output logic             ex_flush,
   output logic [1:0]       pc_src,
   output logic             exc_ack,
   output logic             md_busy,
   output logic             md_timeout
);

   localparam int HOLD_W = (EXC_HOLD_CYCLES < 2) ? 1 : $clog2(EXC_HOLD_CYCLES);
   localparam logic [MD_CNT_W-1:0] MD_LAST   = MD_CNT_W'(MD_TIMEOUT - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(EXC_HOLD_CYCLES - 1);

   pipe_ctrl_state_t    state_q, state_d;
   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   pc_src_t             pc_sel;
   logic                load_use;
   logic                md_stall;

   core_hazard_detect u_hazard (
      .ex_load         (ex_load),
      .ex_write_enable (ex_write_enable),
      .ex_W_regnum     (ex_W_regnum),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_B_is_reg     (id_B_is_reg),
      .load_use        (load_use)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_RUN;
         md_cnt_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         md_cnt_q   <= md_cnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      md_cnt_d   = md_cnt_q;
      hold_cnt_d = hold_cnt_q;
      pc_sel     = PC_SEQ;
      if_stall   = 1'b0;
      id_stall   = 1'b0;
      id_flush   = 1'b0;
      ex_flush   = 1'b0;
      exc_ack    = 1'b0;
      md_busy    = 1'b0;
      md_timeout = 1'b0;
      md_stall   = 1'b0;

      if (!reset) begin
         if (state_q == ST_EXC_HOLD) begin
            // Post-exception shadow: keep ID empty and mask every new event
            id_flush   = 1'b1;
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end
         end else if (exc_req || eret_req) begin
            id_flush   = 1'b1;
            ex_flush   = 1'b1;
            pc_sel     = exc_req ? PC_EXC_VEC : PC_EPC;
            exc_ack    = exc_req;
            state_d    = ST_EXC_HOLD;
            hold_cnt_d = '0;
            md_cnt_d   = '0;
         end else begin
            if (state_q == ST_MD_WAIT) begin
               md_busy  = 1'b1;
               md_cnt_d = md_cnt_q + MD_CNT_W'(1);
               if (md_done) begin
                  state_d  = ST_RUN;
                  md_cnt_d = '0;
               end else if (md_cnt_q == MD_LAST) begin
                  md_timeout = 1'b1;
                  state_d    = ST_RUN;
                  md_cnt_d   = '0;
               end else begin
                  md_stall = id_md_use;
               end
            end else if (ex_md_start) begin
               state_d  = ST_MD_WAIT;
               md_cnt_d = '0;
            end

            // A taken branch flushes ID anyway, so any stall would be wasted
            if (ex_branch_taken) begin
               pc_sel   = PC_BRANCH;
               id_flush = 1'b1;
            end else if (md_stall || load_use) begin
               if_stall = 1'b1;
               id_stall = 1'b1;
            end
         end
      end
   end

   assign pc_src = pc_sel;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl: hazards, branch priority, mul/div wait
// and watchdog, exception/ERET hold window and reset recovery.
module tb_core_pipe_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_W_regnum;
   logic       id_uses_rs, id_B_is_reg, id_md_use;
   logic       ex_load, ex_write_enable, ex_branch_taken, ex_md_start;
   logic       md_done, exc_req, eret_req;
   logic       if_stall, id_stall, id_flush, ex_flush;
   logic [1:0] pc_src;
   logic       exc_ack, md_busy, md_timeout;

   int n_cmp = 0;
   int n_err = 0;

   core_pipe_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_B_is_reg     (id_B_is_reg),
      .id_md_use       (id_md_use),
      .ex_load         (ex_load),
      .ex_write_enable (ex_write_enable),
      .ex_W_regnum     (ex_W_regnum),
      .ex_branch_taken (ex_branch_taken),
      .ex_md_start     (ex_md_start),
      .md_done         (md_done),
      .exc_req         (exc_req),
      .eret_req        (eret_req),
      .if_stall        (if_stall),
      .id_stall        (id_stall),
      .id_flush        (id_flush),
      .ex_flush        (ex_flush),
      .pc_src          (pc_src),
      .exc_ack         (exc_ack),
      .md_busy         (md_busy),
      .md_timeout      (md_timeout)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b (ifs ids idf exf pc[2] ack busy to)", tag, got, exp);
      end
   endtask

   // Check the current cycle's outputs at the falling edge, then advance one cycle
   task automatic cyc_chk(input string tag, input logic ifs, input logic ids, input logic idf,
                          input logic exf, input logic [1:0] pcs, input logic ack,
                          input logic busy, input logic to);
      @(negedge clock);
      check_eq(tag, {if_stall, id_stall, id_flush, ex_flush, pc_src, exc_ack, md_busy, md_timeout},
               {ifs, ids, idf, exf, pcs, ack, busy, to});
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      id_rs = 5'd0; id_rt = 5'd0; ex_W_regnum = 5'd0;
      id_uses_rs = 1'b0; id_B_is_reg = 1'b0; id_md_use = 1'b0;
      ex_load = 1'b0; ex_write_enable = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
      md_done = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
   endtask

   task automatic set_load_use();
      ex_load = 1'b1; ex_write_enable = 1'b1; ex_W_regnum = 5'd8;
      id_rs = 5'd8; id_uses_rs = 1'b1;
   endtask

   initial begin
      clr();
      reset = 1'b1;
      @(posedge clock);
      #1;
      exc_req = 1'b1; ex_branch_taken = 1'b1; set_load_use();
      cyc_chk("reset_outputs", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      reset = 1'b0;
      clr();
      cyc_chk("idle", 0, 0, 0, 0, 2'd0, 0, 0, 0);

      // Load-use on rs, then the load has moved on
      set_load_use();
      cyc_chk("lu_rs", 1, 1, 0, 0, 2'd0, 0, 0, 0);
      clr();
      cyc_chk("lu_released", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      ex_load = 1'b1; ex_write_enable = 1'b1; ex_W_regnum = 5'd8;
      id_rt = 5'd8; id_B_is_reg = 1'b1;
      cyc_chk("lu_rt", 1, 1, 0, 0, 2'd0, 0, 0, 0);
      clr();
      ex_load = 1'b1; ex_write_enable = 1'b1; ex_W_regnum = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      cyc_chk("lu_reg0", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      ex_W_regnum = 5'd8; id_rs = 5'd9;
      cyc_chk("lu_nomatch", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      id_rs = 5'd8; ex_write_enable = 1'b0;
      cyc_chk("lu_nowrite", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      clr();

      // Branch beats load-use
      set_load_use(); ex_branch_taken = 1'b1;
      cyc_chk("branch_over_lu", 0, 0, 1, 0, 2'd1, 0, 0, 0);
      clr();

      // Mul/div completes at cycle 7
      ex_md_start = 1'b1;
      cyc_chk("md_start", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      ex_md_start = 1'b0; id_md_use = 1'b1;
      for (int i = 1; i <= 6; i++) cyc_chk("md_wait_stall", 1, 1, 0, 0, 2'd0, 0, 1, 0);
      md_done = 1'b1;
      cyc_chk("md_done", 0, 0, 0, 0, 2'd0, 0, 1, 0);
      md_done = 1'b0;
      cyc_chk("md_after_done", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      clr();

      // Watchdog: no md_done; branch at cycle 5 and a second start are absorbed
      ex_md_start = 1'b1;
      cyc_chk("to_start", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      id_md_use = 1'b1;
      for (int i = 1; i <= 39; i++) begin
         ex_md_start = (i == 3);
         ex_branch_taken = (i == 5);
         if (i == 5) cyc_chk("md_wait_branch", 0, 0, 1, 0, 2'd1, 0, 1, 0);
         else        cyc_chk("to_wait", 1, 1, 0, 0, 2'd0, 0, 1, 0);
      end
      ex_md_start = 1'b0; ex_branch_taken = 1'b0; id_md_use = 1'b0;
      cyc_chk("md_timeout", 0, 0, 0, 0, 2'd0, 0, 1, 1);
      id_md_use = 1'b1;
      cyc_chk("to_after", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      clr();

      // exc + eret together during MD_WAIT, then the masked hold window
      ex_md_start = 1'b1;
      cyc_chk("exc_md_start", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      ex_md_start = 1'b0;
      cyc_chk("exc_md_busy", 0, 0, 0, 0, 2'd0, 0, 1, 0);
      exc_req = 1'b1; eret_req = 1'b1;
      cyc_chk("exc_wins", 0, 0, 1, 1, 2'd2, 1, 0, 0);
      eret_req = 1'b0; ex_branch_taken = 1'b1; set_load_use();
      cyc_chk("hold1_masked", 0, 0, 1, 0, 2'd0, 0, 0, 0);
      cyc_chk("hold2_masked", 0, 0, 1, 0, 2'd0, 0, 0, 0);
      clr(); id_md_use = 1'b1;
      cyc_chk("hold_exit_md_gone", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      clr();

      // ERET alone, reset in the first hold cycle
      eret_req = 1'b1;
      cyc_chk("eret", 0, 0, 1, 1, 2'd3, 0, 0, 0);
      eret_req = 1'b0; reset = 1'b1;
      cyc_chk("reset_in_hold", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      reset = 1'b0; ex_branch_taken = 1'b1;
      cyc_chk("run_after_reset", 0, 0, 1, 0, 2'd1, 0, 0, 0);
      clr();

      // Reset during MD_WAIT abandons the wait
      ex_md_start = 1'b1;
      cyc_chk("rst_md_start", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      ex_md_start = 1'b0; reset = 1'b1; id_md_use = 1'b1;
      cyc_chk("reset_in_md", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      reset = 1'b0;
      cyc_chk("md_cleared", 0, 0, 0, 0, 2'd0, 0, 0, 0);
      clr();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
